// File: rtl/bcd_sum_display.sv
// ---------------------------------------------------------------------------
// bcd_sum_display
//
// Purpose
//   Captures the 3-digit BCD sum {S2,S1,S0} from the 2-digit BCD adder on a
//   load strobe. It drives a time-multiplexed 3-digit seven-segment display
//   that scans digit 0, 1, 2 and then repeats. A captured digit above 9
//   raises err, and every digit then shows "E". Until the first load after
//   reset, all digits are blank.
//
// Parameters
//   REFRESH_DIV     Clock cycles per digit slot (>= 2).
//   SEG_ACTIVE_LOW  1: seg/an are active-low, 0: active-high.
//
// Compile-time option
//   LEADING_ZERO_BLANK_EN  When defined, leading zeros are blanked:
//                          - digit 2 is blank when S2 = 0;
//                          - digit 1 is blank when S2 = 0 and S1 = 0;
//                          - digit 0 is never blanked;
//                          - the error display overrides blanking.
//
// Ports
//   Clock      in   1  Rising-edge clock.
//   Resetn     in   1  Synchronous, active-low reset.
//   load       in   1  Capture S2/S1/S0 on this edge.
//   S0         in   4  Units digit (BCD).
//   S1         in   4  Tens digit (BCD).
//   S2         in   1  Hundreds digit / carry.
//   an         out  3  One-hot digit enable; an[i] selects digit i.
//   seg        out  7  Segments {g,f,e,d,c,b,a} of the selected digit.
//   err        out  1  Captured sum holds a digit greater than 9.
//   slot_tick  out  1  High for the last divider cycle of each slot.
// ---------------------------------------------------------------------------
module bcd_sum_display #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       load,
  input  logic [3:0] S0,
  input  logic [3:0] S1,
  input  logic       S2,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       err,
  output logic       slot_tick
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  // Digit pointer states. The code 2'b11 is never entered.
  localparam logic [1:0] DIGIT_0 = 2'd0;
  localparam logic [1:0] DIGIT_1 = 2'd1;
  localparam logic [1:0] DIGIT_2 = 2'd2;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
  localparam logic [6:0] GLYPH_E     = 7'b1111001;

  // Output polarity is applied once, when seg/an are registered. The
  // decode logic therefore always works in active-high terms.
  localparam logic [6:0] SEG_POL_MASK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_POL_MASK  = SEG_ACTIVE_LOW ? 3'h7  : 3'h0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ_BLANK = 1'b1;
`else
  localparam bit LZ_BLANK = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [3:0]       cap_s0;
  logic [3:0]       cap_s1;
  logic             cap_s2;
  logic             err_q;
  logic             loaded;      // a load has happened since reset
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       digit_ptr;
  logic [2:0]       an_q;
  logic [6:0]       seg_q;

  logic             div_wrap;
  logic [1:0]       ptr_next;
  logic [2:0]       an_next;
  logic [6:0]       seg_next;
  logic [3:0]       digit_val;
  logic             digit_blank;

  // -------------------------------------------------------------------------
  // Standard 0-9 glyphs. Codes above 9 never reach the display, because
  // err_q overrides them. They map to blank so that the decode stays total.
  // -------------------------------------------------------------------------
  function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b0111111;
      4'd1:    g = 7'b0000110;
      4'd2:    g = 7'b1011011;
      4'd3:    g = 7'b1001111;
      4'd4:    g = 7'b1100110;
      4'd5:    g = 7'b1101101;
      4'd6:    g = 7'b1111101;
      4'd7:    g = 7'b0000111;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1101111;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // -------------------------------------------------------------------------
  // Capture register and error flag
  // -------------------------------------------------------------------------
  // NOTE: sequential state is always written with non-blocking (<=)
  // assignments. Every flop then samples values from before the edge, and
  // the order of the always_ff blocks does not change the result.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cap_s0 <= 4'd0;
      cap_s1 <= 4'd0;
      cap_s2 <= 1'b0;
      err_q  <= 1'b0;
      loaded <= 1'b0;
    end else if (load) begin
      cap_s0 <= S0;
      cap_s1 <= S1;
      cap_s2 <= S2;
      err_q  <= (S0 > 4'd9) || (S1 > 4'd9);
      loaded <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Refresh divider and digit pointer
  // -------------------------------------------------------------------------
  assign div_wrap  = (div_cnt == DIV_LAST);
  assign slot_tick = div_wrap;

  always_comb begin
    case (digit_ptr)
      DIGIT_0: ptr_next = DIGIT_1;
      DIGIT_1: ptr_next = DIGIT_2;
      default: ptr_next = DIGIT_0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      div_cnt   <= '0;
      digit_ptr <= DIGIT_0;
    end else if (div_wrap) begin
      div_cnt   <= '0;
      digit_ptr <= ptr_next;
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Digit select and decode. The inputs are the registered pointer and the
  // registered capture. A load and a pointer advance on the same edge
  // therefore both appear in the next registered seg/an.
  // -------------------------------------------------------------------------
  // NOTE: every signal written here is given a default first, so that no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    an_next     = 3'b001;
    digit_val   = 4'd0;
    digit_blank = 1'b0;
    seg_next    = GLYPH_BLANK;

    case (digit_ptr)
      DIGIT_0: begin
        an_next   = 3'b001;
        digit_val = cap_s0;
      end
      DIGIT_1: begin
        an_next     = 3'b010;
        digit_val   = cap_s1;
        digit_blank = LZ_BLANK && !cap_s2 && (cap_s1 == 4'd0);
      end
      default: begin
        an_next     = 3'b100;
        digit_val   = {3'b000, cap_s2};
        digit_blank = LZ_BLANK && !cap_s2;
      end
    endcase

    if (!loaded) begin
      seg_next = GLYPH_BLANK;
    end else if (err_q) begin
      seg_next = GLYPH_E;
    end else if (digit_blank) begin
      seg_next = GLYPH_BLANK;
    end else begin
      seg_next = bcd_glyph(digit_val);
    end
  end

  // -------------------------------------------------------------------------
  // Output registers. an and seg load on the same edge, so a digit never
  // shows another digit's segments, even for a moment.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      an_q  <= 3'b001 ^ AN_POL_MASK;
      seg_q <= GLYPH_BLANK ^ SEG_POL_MASK;
    end else begin
      an_q  <= an_next ^ AN_POL_MASK;
      seg_q <= seg_next ^ SEG_POL_MASK;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_sum_display.sv
// ---------------------------------------------------------------------------
// tb_bcd_sum_display
//
// Self-checking bench for bcd_sum_display, with REFRESH_DIV = 4 and active-low
// outputs.
//
// The vector table covers full scans of captured values. Each load pushes the
// three expected {an, seg} slots into a scoreboard queue. The bench pops one
// slot each time the DUT has held it for four cycles.
//
// Hand-written sequences cover:
//   - reset;
//   - the blank display before the first load;
//   - a load on the divider-wrap edge;
//   - a reset in the middle of a slot.
// ---------------------------------------------------------------------------
module tb_bcd_sum_display;

  localparam int DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  // Active-low expected glyphs.
  localparam logic [6:0] L_0 = 7'b1000000;
  localparam logic [6:0] L_1 = 7'b1111001;
  localparam logic [6:0] L_2 = 7'b0100100;
  localparam logic [6:0] L_4 = 7'b0011001;
  localparam logic [6:0] L_5 = 7'b0010010;
  localparam logic [6:0] L_6 = 7'b0000010;
  localparam logic [6:0] L_7 = 7'b1111000;
  localparam logic [6:0] L_8 = 7'b0000000;
  localparam logic [6:0] L_9 = 7'b0010000;
  localparam logic [6:0] L_E = 7'b0000110;
  localparam logic [6:0] L_B = 7'b1111111;

  localparam logic [2:0] AN0 = 3'b110;
  localparam logic [2:0] AN1 = 3'b101;
  localparam logic [2:0] AN2 = 3'b011;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       load;
  logic [3:0] S0;
  logic [3:0] S1;
  logic       S2;
  logic [2:0] an;
  logic [6:0] seg;
  logic       err;
  logic       slot_tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       s2;
    logic [3:0] s1;
    logic [3:0] s0;
    logic [6:0] d0;
    logic [6:0] d1;
    logic [6:0] d2;
    logic       e;
  } vec_t;

  vec_t       vecs[8];
  logic [9:0] sb_q[$];

  bcd_sum_display #(
    .REFRESH_DIV   (DIV),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .load     (load),
    .S0       (S0),
    .S1       (S1),
    .S2       (S2),
    .an       (an),
    .seg      (seg),
    .err      (err),
    .slot_tick(slot_tick)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock edge, then return at the following falling edge. The
  // bench samples outputs there and drives the next inputs there.
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Wait for the first cycle in which an has newly switched to 'want'.
  task automatic wait_slot_start(input logic [2:0] want, output bit ok);
    logic [2:0] prev;
    prev = an;
    ok   = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (an == want && prev != want) begin
        ok = 1'b1;
        break;
      end
      prev = an;
    end
  endtask

  task automatic drive_load(input logic s2, input logic [3:0] s1, input logic [3:0] s0);
    S2   = s2;
    S1   = s1;
    S0   = s0;
    load = 1'b1;
  endtask

  initial begin
    bit ok;
    int ticks;

    vecs[0] = '{1'b1, 4'd5, 4'd0, L_0, L_5, L_1, 1'b0};
    vecs[1] = '{1'b0, 4'hA, 4'd3, L_E, L_E, L_E, 1'b1};
    vecs[2] = '{1'b0, 4'd9, 4'd8, L_8, L_9, LZB ? L_B : L_0, 1'b0};
    vecs[3] = '{1'b0, 4'd0, 4'd7, L_7, LZB ? L_B : L_0, LZB ? L_B : L_0, 1'b0};
    vecs[4] = '{1'b1, 4'd2, 4'd4, L_4, L_2, L_1, 1'b0};
    vecs[5] = '{1'b0, 4'd3, 4'hF, L_E, L_E, L_E, 1'b1};
    vecs[6] = '{1'b1, 4'd6, 4'd9, L_9, L_6, L_1, 1'b0};
    vecs[7] = '{1'b0, 4'd1, 4'd1, L_1, L_1, LZB ? L_B : L_0, 1'b0};

    Resetn = 1'b0;
    load   = 1'b0;
    S0     = 4'd0;
    S1     = 4'd0;
    S2     = 1'b0;

    // Reset held for 2 cycles.
    tick();
    tick();
    check("reset an", 32'(an), 32'(AN0));
    check("reset seg", 32'(seg), 32'(L_B));
    check("reset err", 32'(err), 32'd0);
    check("reset slot_tick", 32'(slot_tick), 32'd0);

    // After release, slot_tick first pulses in the 4th cycle.
    Resetn = 1'b1;
    tick();
    check("tick after release c1", 32'(slot_tick), 32'd0);
    tick();
    check("tick after release c2", 32'(slot_tick), 32'd0);
    tick();
    check("tick after release c3", 32'(slot_tick), 32'd1);

    // Before any load, the scan runs but every digit stays blank.
    wait_slot_start(AN1, ok);
    check("reach slot1 before load", 32'(ok), 32'd1);
    check("blank before first load", 32'(seg), 32'(L_B));

    // Table-driven full scans.
    for (int i = 0; i < 8; i++) begin
      drive_load(vecs[i].s2, vecs[i].s1, vecs[i].s0);
      sb_q.push_back({AN0, vecs[i].d0});
      sb_q.push_back({AN1, vecs[i].d1});
      sb_q.push_back({AN2, vecs[i].d2});
      tick();
      load = 1'b0;
      check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].e));
      wait_slot_start(AN0, ok);
      if (!ok) begin
        check($sformatf("vec%0d slot0 timeout", i), 32'd0, 32'd1);
        sb_q.delete();
      end else begin
        for (int c = 0; c < 3 * DIV; c++) begin
          check($sformatf("vec%0d cycle%0d an/seg", i, c), 32'({an, seg}), 32'(sb_q[0]));
          if (c % DIV == DIV - 1) void'(sb_q.pop_front());
          if (c < 3 * DIV - 1) tick();
        end
        check($sformatf("vec%0d scoreboard drained", i), 32'(sb_q.size()), 32'd0);
      end
    end

    // Load on the same edge as the divider wrap at the end of slot 0.
    // The captured value before this load is 0/1/1, shown as "1" on digit 0.
    wait_slot_start(AN0, ok);
    check("wrap-load align", 32'(ok), 32'd1);
    tick();
    tick();
    check("wrap-load tick high", 32'(slot_tick), 32'd1);
    drive_load(1'b0, 4'd2, 4'd3);
    tick();
    load = 1'b0;
    check("wrap-load old digit0", 32'({an, seg}), 32'({AN0, L_1}));
    tick();
    check("wrap-load new digit1", 32'({an, seg}), 32'({AN1, L_2}));
    ticks = 0;
    for (int c = 0; c < 3 * DIV; c++) begin
      tick();
      if (slot_tick) ticks++;
    end
    check("wrap-load tick count", 32'(ticks), 32'd3);

    // Reset pulsed low mid-slot, with divider = 2 and pointer = 1.
    wait_slot_start(AN1, ok);
    check("midslot align", 32'(ok), 32'd1);
    tick();
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    check("midslot reset an", 32'(an), 32'(AN0));
    check("midslot reset seg", 32'(seg), 32'(L_B));
    check("midslot reset err", 32'(err), 32'd0);
    check("midslot reset tick", 32'(slot_tick), 32'd0);
    tick();
    check("restart c1", 32'(slot_tick), 32'd0);
    tick();
    check("restart c2", 32'(slot_tick), 32'd0);
    tick();
    check("restart c3", 32'(slot_tick), 32'd1);
    wait_slot_start(AN1, ok);
    check("restart slot1", 32'(ok), 32'd1);
    check("capture cleared", 32'(seg), 32'(L_B));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
